ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10000, clk cycles ps2 clock is held low before request-to-send (100 us at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 1500000, max clk cycles from clock release to completion (15 ms at 100 MHz).
REQ-003 clk  input  1  system clock, single clock domain.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 tx_data  input  8  command/data byte to send to keyboard (e.g. 0xED LED command).
REQ-006 tx_valid  input  1  request; byte accepted on a cycle with tx_valid=1 and tx_ready=1.
REQ-007 tx_ready  output  1  high only in IDLE.
REQ-008 ps2_clk_in  input  1  raw PS2_CLK line level (asynchronous).
REQ-009 ps2_data_in  input  1  raw PS2_DATA line level (asynchronous).
REQ-010 ps2_clk_oe  output  1  1 = drive PS2_CLK low; 0 = release (open-drain, pulled high).
REQ-011 ps2_data_oe  output  1  1 = drive PS2_DATA low; 0 = release.
REQ-012 done  output  1  one-cycle pulse, byte sent and acknowledged by device.
REQ-013 err  output  1  one-cycle pulse, missing ack or timeout.

Function
REQ-014 Both ps2 inputs pass through a 2-flop synchronizer; a falling edge is synchronized-previous=1 and synchronized-current=0.
REQ-015 States: IDLE, INHIBIT, DATA_LOW, RTS, SHIFT, ACK, WAIT_IDLE.
REQ-016 IDLE: clk_oe=0, data_oe=0, tx_ready=1; on accept, latch tx_data and odd parity (parity = ~^tx_data), go INHIBIT.
REQ-017 INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then DATA_LOW.
REQ-018 DATA_LOW: clk_oe=1, data_oe=1 for exactly one cycle (start bit 0), then RTS.
REQ-019 RTS: clk_oe=0, data_oe=1; timeout counter starts at 0 on entry; falling edge count k=0.
REQ-020 SHIFT: on synchronized falling edge k=1..8 set data_oe=~tx_data[k-1]; k=9 data_oe=~parity; k=10 data_oe=0 (stop bit released); then ACK.
REQ-021 data_oe updates on the clk edge immediately after the falling edge is detected; holds otherwise.
REQ-022 ACK: on next synchronized falling edge sample ps2_data_in: 0 -> WAIT_IDLE; 1 -> err pulse, IDLE.
REQ-023 WAIT_IDLE: when both synchronized lines are high, pulse done, go IDLE.
REQ-024 Timeout: in RTS, SHIFT, ACK, WAIT_IDLE, when counter reaches TIMEOUT_CYCLES release both lines, pulse err, go IDLE; counter saturates, never wraps.
REQ-025 tx_valid outside IDLE ignored, no queuing; done and err never high together.
REQ-026 Falling edges in IDLE, INHIBIT, DATA_LOW ignored (keyboard receive path unaffected).

Reset
REQ-027 rst=0 at a clk edge: state IDLE, clk_oe=0, data_oe=0, tx_ready=1, done=0, err=0, counters and edge count 0, synchronizers 1.
REQ-028 Reset mid-transfer releases both lines on the next clk edge and discards the byte; no done/err pulse.

Verification (INHIBIT_CYCLES=4, TIMEOUT_CYCLES=200)
REQ-029 Send 0xED, device model clocks 11 edges, acks low -> data_oe sequence after start 0: 0,1,0,0,1,0,0,0 then parity 0 (line 1), stop released; done once, tx_ready high after.
REQ-030 Send 0x01 -> parity line 0 (data_oe=1 on edge 9); send 0x00 -> parity line 1; done each.
REQ-031 Accept -> clk_oe high exactly 4 cycles, then 1 cycle both oe high, then clk_oe=0 with data_oe=1.
REQ-032 Device leaves data high at ack edge -> err pulse, no done, IDLE.
REQ-033 No device clock after release -> err exactly at counter 200, both oe 0.
REQ-034 rst=0 at edge 5 of SHIFT -> next cycle both oe 0, tx_ready=1; tx_valid during SHIFT ignored.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to a keyboard using the PS/2 request-to-send sequence:
// inhibit the clock, pull data low, release the clock, then put one bit on the
// data line after each device-generated falling clock edge, and finally check
// the device acknowledge bit. Both PS/2 lines are open-drain; the *_oe outputs
// pull a line low when set.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       err
);

  // One counter serves both the inhibit delay and the transfer timeout.
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_DATA_LOW,
    S_RTS,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       bit_cnt;    // device falling edges seen since the clock was released
  logic [8:0]       shreg;      // {parity, data}, shifted out LSB first
  logic             clk_meta, clk_sync, clk_prev;
  logic             data_meta, data_sync;
  logic             clk_fall;
  logic             timeout;

  // Two-flop synchronizers on both lines, plus a history flop for clock edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge value of the others; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  assign clk_fall = clk_prev & ~clk_sync;

  // Saturating increment: the timeout counter can never wrap back to a small value.
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
  assign timeout = (cnt_inc >= CNT_W'(TIMEOUT_CYCLES));

  // Transfer sequencer with registered line drivers and handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      tx_ready    <= 1'b1;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_valid) begin
            shreg      <= {~^tx_data, tx_data};   // odd parity
            cnt        <= '0;
            tx_ready   <= 1'b0;
            ps2_clk_oe <= 1'b1;
            state      <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
            ps2_data_oe <= 1'b1;                  // start bit
            state       <= S_DATA_LOW;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DATA_LOW: begin
          ps2_clk_oe <= 1'b0;                     // hand the clock to the device
          cnt        <= '0;
          bit_cnt    <= '0;
          state      <= S_RTS;
        end

        default: begin
          cnt <= cnt_inc;
          if (timeout) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            err         <= 1'b1;
            state       <= S_IDLE;
          end else begin
            case (state)
              S_RTS, S_SHIFT: begin
                if (clk_fall) begin
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd9) begin
                    ps2_data_oe <= 1'b0;          // stop bit: release the line
                    state       <= S_ACK;
                  end else begin
                    ps2_data_oe <= ~shreg[0];     // edges 1..8 data, edge 9 parity
                    shreg       <= shreg >> 1;
                    state       <= S_SHIFT;
                  end
                end
              end

              S_ACK: begin
                if (clk_fall) begin
                  if (!data_sync) begin
                    state <= S_WAIT_IDLE;
                  end else begin
                    err      <= 1'b1;
                    tx_ready <= 1'b1;
                    state    <= S_IDLE;
                  end
                end
              end

              S_WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                  done     <= 1'b1;
                  tx_ready <= 1'b1;
                  state    <= S_IDLE;
                end
              end

              default: begin
                state <= S_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a PS/2 device model drives the shared open-drain
// lines, records the bits it samples on rising clock edges and compares them
// to frames built from the byte (data LSB first, odd parity, stop=1). A
// per-cycle monitor checks the request-to-send timeline, done/err exclusivity
// and the release-to-timeout distance.
module tb_ps2_host_tx;

  localparam int INHIBIT = 4;
  localparam int TIMEOUT = 200;
  localparam int HALF    = 5;     // device clock half period in system clocks

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       done;
  logic       err;

  logic dev_clk;
  logic dev_data;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int err_rel = -1;
  logic err_clk_oe = 1'b1;
  logic err_data_oe = 1'b1;

  // monitor state
  int   phase = 0;
  int   rel = 0;
  bit   in_txn = 0;
  logic prev_clk_oe = 1'b0;

  // Open-drain bus: a line is low if either side pulls it low.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame as seen on the data line: {stop, odd parity, data}, bit 0 first.
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
  endfunction

  // Per-cycle monitor, sampling just after the falling clock edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        phase       = 0;
        in_txn      = 0;
        prev_clk_oe = 1'b0;
      end else begin
        check("done_err_exclusive", {31'd0, done & err}, 32'd0);
        if (phase > 0) begin
          if (phase <= INHIBIT) begin
            check("inhibit_clk_oe", ps2_clk_oe, 1);
            check("inhibit_data_oe", ps2_data_oe, 0);
            check("inhibit_ready", tx_ready, 0);
          end else if (phase == INHIBIT + 1) begin
            check("start_clk_oe", ps2_clk_oe, 1);
            check("start_data_oe", ps2_data_oe, 1);
          end else begin
            check("rts_clk_oe", ps2_clk_oe, 0);
            check("rts_data_oe", ps2_data_oe, 1);
          end
          phase = (phase == INHIBIT + 2) ? 0 : phase + 1;
        end
        if (tx_valid && tx_ready) phase = 1;

        if (prev_clk_oe && !ps2_clk_oe) begin
          rel    = 0;
          in_txn = 1;
        end else if (in_txn) begin
          rel++;
        end
        prev_clk_oe = ps2_clk_oe;

        if (done) begin
          done_cnt++;
          in_txn = 0;
          check("ready_after_done", tx_ready, 1);
        end
        if (err) begin
          err_cnt++;
          err_rel     = in_txn ? rel : -1;
          err_clk_oe  = ps2_clk_oe;
          err_data_oe = ps2_data_oe;
          in_txn      = 0;
          check("ready_after_err", tx_ready, 1);
        end
      end
    end
  end

  task automatic start(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_rts();
    int guard = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("rts_reached", {31'd0, guard < 50}, 32'd1);
  endtask

  // One device clock pulse; the data line is sampled just before the rising edge.
  task automatic dev_pulse(output logic line);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    line    = ps2_data_in;
    dev_clk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic device_xfer(input bit give_ack, output logic [9:0] bits);
    logic b;
    wait_rts();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      dev_pulse(b);
      bits[k] = b;
    end
    if (give_ack) dev_data = 1'b0;
    dev_pulse(b);
    dev_data = 1'b1;
  endtask

  task automatic send_and_check(input logic [7:0] d, input bit give_ack, input logic [9:0] lit);
    int d0 = done_cnt;
    int e0 = err_cnt;
    logic [9:0] bits;
    start(d);
    device_xfer(give_ack, bits);
    check("frame_model", {22'd0, bits}, {22'd0, model_frame(d)});
    check("frame_literal", {22'd0, bits}, {22'd0, lit});
    repeat (40) @(negedge clk);
    check("done_count", done_cnt - d0, give_ack ? 1 : 0);
    check("err_count", err_cnt - e0, give_ack ? 0 : 1);
    check("ready_idle", tx_ready, 1);
    check("idle_clk_oe", ps2_clk_oe, 0);
    check("idle_data_oe", ps2_data_oe, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int e0;
    logic [3:0] early;
    logic b;

    rst      = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ready", tx_ready, 1);
    check("reset_clk_oe", ps2_clk_oe, 0);
    check("reset_data_oe", ps2_data_oe, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    rst = 1'b1;
    @(negedge clk);

    // Normal transfers with acknowledge.
    send_and_check(8'hED, 1'b1, 10'h3ED);
    send_and_check(8'h01, 1'b1, 10'h201);
    send_and_check(8'h00, 1'b1, 10'h300);

    // Device leaves data high at the acknowledge edge.
    send_and_check(8'h3C, 1'b0, 10'h33C);

    // No device clock at all: timeout after exactly TIMEOUT cycles from release.
    d0 = done_cnt;
    e0 = err_cnt;
    start(8'h5A);
    repeat (TIMEOUT + 60) @(negedge clk);
    check("timeout_err_count", err_cnt - e0, 1);
    check("timeout_done_count", done_cnt - d0, 0);
    check("timeout_cycles", err_rel, TIMEOUT);
    check("timeout_clk_oe", err_clk_oe, 0);
    check("timeout_data_oe", err_data_oe, 0);

    // Reset at the fifth device edge; a request during SHIFT is ignored.
    d0 = done_cnt;
    e0 = err_cnt;
    start(8'hED);
    wait_rts();
    repeat (2) @(negedge clk);
    dev_pulse(b);
    early[0] = b;
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    dev_pulse(b);
    early[1] = b;
    check("shift_ready_low", tx_ready, 0);
    dev_pulse(b);
    early[2] = b;
    tx_valid = 1'b0;
    dev_pulse(b);
    early[3] = b;
    check("shift_first_bits", {28'd0, early}, 32'hD);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    check("edge5_data_oe", ps2_data_oe, 1);
    rst = 1'b0;
    @(negedge clk);
    check("midreset_clk_oe", ps2_clk_oe, 0);
    check("midreset_data_oe", ps2_data_oe, 0);
    check("midreset_ready", tx_ready, 1);
    rst     = 1'b1;
    dev_clk = 1'b1;
    repeat (TIMEOUT + 50) @(negedge clk);
    check("midreset_no_done", done_cnt - d0, 0);
    check("midreset_no_err", err_cnt - e0, 0);
    check("midreset_idle_ready", tx_ready, 1);

    // Recovery after reset.
    send_and_check(8'hF4, 1'b1, 10'h2F4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
